game_timer: RTL
===============

Name: game_timer

Overview:
- Upstream game-flow controller for the LED whack-a-mole scorer.
- Generates its `start` level, which is high for the whole timed game window.
- Generates its `change` pulse, which tells it when to light a new LED.
- The change interval shrinks as the game progresses (difficulty levels).
- Exposes seconds remaining and a game-over pulse for display/sound stages.

Parameters:
SEC_CYCLES, 50000000, clock cycles per game second
GAME_SECS, 30, game length in seconds (1..127; 0 illegal)
CHG_INIT, 25000000, initial cycles between change pulses (>= 1)
CHG_MIN, 6250000, floor for the change interval (1..CHG_INIT)
CHG_STEP, 2500000, interval decrement per speed-up
SPEEDUP_EVERY, 8, change pulses per speed-up (>= 1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
go  input  1  start request, synchronized level; rising edge acts
start  output  1  game active level
change  output  1  one-cycle pulse: load new LED
time_left  output  7  seconds remaining
game_over  output  1  one-cycle pulse when time expires
level  output  4  current speed level, saturates at 15

Behaviour:
- Reset (rst=0 at clk edge):
  - Outputs: start=0, change=0, game_over=0, time_left=GAME_SECS, level=0.
  - Internals: state=IDLE, sec_cnt=0, chg_cnt=0, chg_num=0, interval=CHG_INIT.
  - go_q=1, so a go held high through reset release does not start a game.
- Edge detect: go_rise = go & ~go_q; go_q <= go every cycle.
- States IDLE, RUN, DONE; all outputs registered.
- IDLE or DONE, go_rise:
  - Next edge enters RUN with start=1, time_left=GAME_SECS, level=0, interval=CHG_INIT.
  - All counters cleared.
- RUN, go_rise: ignored (no restart mid-game).
- RUN, second timing:
  - sec_cnt increments each cycle.
  - At sec_cnt==SEC_CYCLES-1: sec_cnt<=0, time_left<=time_left-1.
  - If time_left==1 at that edge: enter DONE with start<=0, game_over<=1 for exactly one cycle, time_left<=0.
- RUN, change timing:
  - chg_cnt increments each cycle.
  - At chg_cnt==interval-1: change<=1 for one cycle, chg_cnt<=0, chg_num++.
  - The first change comes a full interval after start rises; no pulse on entry.
- Speed-up:
  - On the change pulse where chg_num==SPEEDUP_EVERY-1: chg_num<=0 and interval<=max(interval-CHG_STEP, CHG_MIN).
  - Compute without underflow: if interval < CHG_MIN+CHG_STEP, load CHG_MIN.
  - level increments (saturating at 15) only if interval actually decreased.
- Simultaneous expiry and change: game end wins; change stays 0 and the counters do not matter afterwards.
- DONE: start=0, change=0, time_left held at 0, level held.
- Reset mid-game: returns immediately to reset values; start drops on that edge.
- Counters are 32-bit unsigned; parameters must fit.

Optional Feature:
- Macro GAME_TIMER_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in RUN: sec_cnt, chg_cnt, chg_num and time_left are frozen, change is forced to 0, start stays 1, go_rise is ignored.
  - Counting resumes from the frozen values on the cycle pause returns to 0.
  - Pause has no effect in IDLE/DONE.
- Undefined: no `pause` port; the timer always runs while in RUN.

Test Plan:
Default bench params: SEC_CYCLES=10, GAME_SECS=3, CHG_INIT=8, CHG_MIN=4, CHG_STEP=2, SPEEDUP_EVERY=2. Cycle counts are edges after start rises.
1. rst=0 for 3 cycles, go=1 throughout, then rst=1 -> start, change, game_over stay 0; time_left=3; level=0; no game starts until go falls and rises again.
2. go pulse from IDLE ->
   - start=1 the next edge.
   - change pulses at cycles 8, 16, 22, 28.
   - level becomes 1 at cycle 16 and 2 at cycle 28.
   - time_left: 2 at cycle 10, 1 at 20, 0 at 30.
   - At cycle 30: start=0 and game_over=1 for one cycle.
3. Params SEC_CYCLES=8, GAME_SECS=1, CHG_INIT=8 -> cycle 8: game_over=1, change=0, start=0.
4. go rising edge at cycle 5 of RUN -> ignored; change still at cycle 8, time_left still 2 at cycle 10.
5. After DONE, go pulse -> start=1, time_left=3, level=0, first change 8 cycles later.
6. GAME_TIMER_PAUSE_EN defined, pause=1 for cycles 4–8 -> first change at cycle 13; time_left reaches 2 at cycle 15; start stays 1 during the pause.

Source files
------------

// File: rtl/game_timer.sv
// Game-flow timer: timed game window, shrinking change-pulse interval, countdown and game-over pulse.
// Optional macro GAME_TIMER_PAUSE_EN adds a pause input that freezes the running game.
module game_timer #(
    parameter int unsigned SEC_CYCLES    = 50000000,
    parameter int unsigned GAME_SECS     = 30,
    parameter int unsigned CHG_INIT      = 25000000,
    parameter int unsigned CHG_MIN       = 6250000,
    parameter int unsigned CHG_STEP      = 2500000,
    parameter int unsigned SPEEDUP_EVERY = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
`ifdef GAME_TIMER_PAUSE_EN
    input  logic       pause,
`endif
    output logic       start,
    output logic       change,
    output logic [6:0] time_left,
    output logic       game_over,
    output logic [3:0] level
);

    localparam logic [31:0] SEC_LAST   = SEC_CYCLES - 1;
    localparam logic [31:0] SPEED_LAST = SPEEDUP_EVERY - 1;
    localparam logic [31:0] INIT_IVAL  = CHG_INIT;
    localparam logic [31:0] MIN_IVAL   = CHG_MIN;
    localparam logic [31:0] STEP_IVAL  = CHG_STEP;
    localparam logic [31:0] NO_UNDER   = CHG_MIN + CHG_STEP;
    localparam logic [6:0]  SECS       = 7'(GAME_SECS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic        go_q_reg;
    logic [31:0] sec_cnt_reg, sec_cnt_next;
    logic [31:0] chg_cnt_reg, chg_cnt_next;
    logic [31:0] chg_num_reg, chg_num_next;
    logic [31:0] interval_reg, interval_next;
    logic        start_reg, start_next;
    logic        change_reg, change_next;
    logic        game_over_reg, game_over_next;
    logic [6:0]  time_left_reg, time_left_next;
    logic [3:0]  level_reg, level_next;

    logic        hold;
    logic        go_rise;
    logic        sec_wrap;
    logic        chg_hit;
    logic [31:0] reduced;

`ifdef GAME_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign go_rise  = go & ~go_q_reg;
    assign sec_wrap = (sec_cnt_reg == SEC_LAST);
    assign chg_hit  = (chg_cnt_reg == interval_reg - 32'd1);
    // Clamp before subtracting so a small interval never wraps below the floor.
    assign reduced  = (interval_reg < NO_UNDER) ? MIN_IVAL : (interval_reg - STEP_IVAL);

    always_comb begin
        state_next     = state_reg;
        sec_cnt_next   = sec_cnt_reg;
        chg_cnt_next   = chg_cnt_reg;
        chg_num_next   = chg_num_reg;
        interval_next  = interval_reg;
        start_next     = start_reg;
        change_next    = 1'b0;
        game_over_next = 1'b0;
        time_left_next = time_left_reg;
        level_next     = level_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (go_rise) begin
                    state_next     = RUN;
                    start_next     = 1'b1;
                    time_left_next = SECS;
                    level_next     = 4'd0;
                    interval_next  = INIT_IVAL;
                    sec_cnt_next   = 32'd0;
                    chg_cnt_next   = 32'd0;
                    chg_num_next   = 32'd0;
                end
            end
            RUN: begin
                if (!hold) begin
                    sec_cnt_next = sec_wrap ? 32'd0 : sec_cnt_reg + 32'd1;
                    chg_cnt_next = chg_hit ? 32'd0 : chg_cnt_reg + 32'd1;
                    if (sec_wrap) begin
                        time_left_next = time_left_reg - 7'd1;
                    end
                    // Expiry takes priority over a coincident change pulse.
                    if (sec_wrap && time_left_reg == 7'd1) begin
                        state_next     = DONE;
                        start_next     = 1'b0;
                        game_over_next = 1'b1;
                        time_left_next = 7'd0;
                    end else if (chg_hit) begin
                        change_next = 1'b1;
                        if (chg_num_reg == SPEED_LAST) begin
                            chg_num_next  = 32'd0;
                            interval_next = reduced;
                            if (reduced < interval_reg && level_reg != 4'd15) begin
                                level_next = level_reg + 4'd1;
                            end
                        end else begin
                            chg_num_next = chg_num_reg + 32'd1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            go_q_reg      <= 1'b1;
            sec_cnt_reg   <= 32'd0;
            chg_cnt_reg   <= 32'd0;
            chg_num_reg   <= 32'd0;
            interval_reg  <= INIT_IVAL;
            start_reg     <= 1'b0;
            change_reg    <= 1'b0;
            game_over_reg <= 1'b0;
            time_left_reg <= SECS;
            level_reg     <= 4'd0;
        end else begin
            state_reg     <= state_next;
            go_q_reg      <= go;
            sec_cnt_reg   <= sec_cnt_next;
            chg_cnt_reg   <= chg_cnt_next;
            chg_num_reg   <= chg_num_next;
            interval_reg  <= interval_next;
            start_reg     <= start_next;
            change_reg    <= change_next;
            game_over_reg <= game_over_next;
            time_left_reg <= time_left_next;
            level_reg     <= level_next;
        end
    end

    assign start     = start_reg;
    assign change    = change_reg;
    assign game_over = game_over_reg;
    assign time_left = time_left_reg;
    assign level     = level_reg;

endmodule
